// File: rtl/p1v_board_io.sv
// Board-to-core glue for p1v: pad synchronisers/filters, registered pad drive,
// and conditioning of raw active-low reset sources into one stretched core reset.

module p1v_rst_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock_160,
  input  logic reset,
  input  logic req_n,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  // Assertion is immediate; release needs an unbroken run of 1 samples.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      rel  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_n};
      if (!sync[SYNC_STAGES-1]) begin
        cnt <= '0;
        rel <= 1'b0;
      end else if (!rel) begin
        if (cnt != CMAX) cnt <= cnt + 1'b1;
        if (cnt == CMAX - 1'b1) rel <= 1'b1;
      end
    end
  end
endmodule

module p1v_pin_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clock_160,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic toggle
);
  localparam int FMAX = (FILTER_CYCLES > 1) ? FILTER_CYCLES : 1;
  localparam int CW   = $clog2(FMAX + 1);
  localparam logic [CW-1:0] CLAST = CW'(FMAX - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clock_160) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pad};
      toggle <= 1'b0;
      if (sync[SYNC_STAGES-1] != level) begin
        if (cnt == CLAST) begin
          level  <= sync[SYNC_STAGES-1];
          cnt    <= '0;
          toggle <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module p1v_board_io #(
  parameter int PINS            = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_CYCLES   = 0,
  parameter int NUM_RST         = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 1024
) (
  input  logic              clock_160,
  input  logic              reset,
  input  logic [NUM_RST-1:0] rst_req_n,
  output logic              core_resn,
  input  logic [PINS-1:0]   pad_in,
  output logic [PINS-1:0]   pad_out,
  output logic [PINS-1:0]   pad_oe,
  output logic [PINS-1:0]   pin_in,
  output logic [PINS-1:0]   pin_edge,
  input  logic [PINS-1:0]   pin_out,
  input  logic [PINS-1:0]   pin_dir
);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] SLOAD = SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_t;

  state_t             state, state_nx;
  logic [SW-1:0]      scnt, scnt_nx;
  logic [NUM_RST-1:0] rel;
  logic [PINS-1:0]    toggle;
  logic               all_rel, any_req, run;

  for (genvar r = 0; r < NUM_RST; r++) begin : g_rst
    p1v_rst_lane #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clock_160(clock_160), .reset(reset), .req_n(rst_req_n[r]), .rel(rel[r])
    );
  end

  for (genvar p = 0; p < PINS; p++) begin : g_pin
    p1v_pin_lane #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_lane (
      .clock_160(clock_160), .reset(reset), .pad(pad_in[p]),
      .level(pin_in[p]), .toggle(toggle[p])
    );
  end

  assign all_rel = &rel;
  assign any_req = !all_rel;

  // A new request always wins over stretch expiry.
  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    case (state)
      HOLD:
        if (all_rel) begin
          state_nx = STRETCH;
          scnt_nx  = SLOAD;
        end
      STRETCH:
        if (any_req)           state_nx = HOLD;
        else if (scnt == '0)   state_nx = RUN;
        else                   scnt_nx  = scnt - 1'b1;
      RUN:
        if (any_req) state_nx = HOLD;
      default: state_nx = HOLD;
    endcase
  end

  always_ff @(posedge clock_160) begin
    if (reset) begin
      state   <= HOLD;
      scnt    <= '0;
      pad_out <= '0;
      pad_oe  <= '0;
    end else begin
      state   <= state_nx;
      scnt    <= scnt_nx;
      pad_out <= pin_out;
      pad_oe  <= pin_dir & {PINS{run}};
    end
  end

  // Decoded straight from the state register so the core reset cannot glitch.
  assign run       = (state == RUN);
  assign core_resn = run;
  assign pin_edge  = toggle & {PINS{run}};
endmodule

// File: tb/tb_p1v_board_io.sv
// Directed bench for p1v_board_io: reset conditioning, input filter, output path.

module tb_p1v_board_io;
  logic       clock_160 = 1'b0;
  logic       reset;
  logic [1:0] rst_req_n;
  logic       core_resn;
  logic [7:0] pad_in, pad_out, pad_oe, pin_in, pin_edge, pin_out, pin_dir;

  int checks = 0;
  int errors = 0;

  p1v_board_io #(
    .PINS(8), .SYNC_STAGES(2), .FILTER_CYCLES(3), .NUM_RST(2),
    .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(8)
  ) dut (
    .clock_160(clock_160), .reset(reset), .rst_req_n(rst_req_n), .core_resn(core_resn),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .pin_in(pin_in),
    .pin_edge(pin_edge), .pin_out(pin_out), .pin_dir(pin_dir)
  );

  always #5 clock_160 = ~clock_160;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_160);
      #1;
    end
  endtask

  initial begin
    logic pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1; rst_req_n = 2'b11; pad_in = '0; pin_out = 8'hFF; pin_dir = 8'hFF;

    // power-up
    step(3);
    chk("rst_core_resn", core_resn, 1'b0);
    chk("rst_pad_out",   pad_out, 8'h00);
    chk("rst_pad_oe",    pad_oe, 8'h00);
    chk("rst_pin_in",    pin_in, 8'h00);
    chk("rst_pin_edge",  pin_edge, 8'h00);
    reset = 1'b0;
    step(14);
    chk("pu_e14_resn", core_resn, 1'b0);
    step(1);
    chk("pu_e15_resn", core_resn, 1'b1);
    chk("pu_e15_oe",   pad_oe, 8'h00);
    step(1);
    chk("pu_e16_oe",   pad_oe, 8'hFF);
    chk("pu_e16_out",  pad_out, 8'hFF);

    // bouncing release on source 1
    rst_req_n[1] = 1'b0;
    step(6);
    chk("bn_hold_resn", core_resn, 1'b0);
    chk("bn_hold_oe",   pad_oe, 8'h00);
    for (int k = 0; k < 8; k++) begin
      rst_req_n[1] = pat[k];
      step(1);
    end
    step(10);
    chk("bn_e18_resn", core_resn, 1'b0);
    step(1);
    chk("bn_e19_resn", core_resn, 1'b1);
    step(1);
    chk("bn_e20_oe", pad_oe, 8'hFF);

    // input filter: 2-cycle glitch must be ignored
    for (int k = 0; k < 10; k++) begin
      pad_in = (k < 2) ? 8'h08 : 8'h00;
      step(1);
      chk("flt_glitch_in",   pin_in, 8'h00);
      chk("flt_glitch_edge", pin_edge, 8'h00);
    end
    pad_in = 8'h08;
    step(4);
    chk("flt_e4_in", pin_in, 8'h00);
    step(1);
    chk("flt_e5_in",   pin_in, 8'h08);
    chk("flt_e5_edge", pin_edge, 8'h08);
    step(1);
    chk("flt_e6_in",   pin_in, 8'h08);
    chk("flt_e6_edge", pin_edge, 8'h00);

    // output path and forced float
    pin_dir = 8'hF0; pin_out = 8'hA5;
    step(1);
    chk("out_oe",  pad_oe, 8'hF0);
    chk("out_out", pad_out, 8'hA5);
    rst_req_n[0] = 1'b0;
    step(3);
    chk("fl_e3_resn", core_resn, 1'b1);
    step(1);
    chk("fl_e4_resn", core_resn, 1'b0);
    chk("fl_e4_oe",   pad_oe, 8'hF0);
    step(1);
    chk("fl_e5_oe",  pad_oe, 8'h00);
    chk("fl_e5_out", pad_out, 8'hA5);

    // mid-stretch request
    rst_req_n[0] = 1'b1;
    step(7);
    chk("ms_e7_resn", core_resn, 1'b0);
    step(1);
    rst_req_n[0] = 1'b0;
    step(1);
    rst_req_n[0] = 1'b1;
    step(7);
    chk("ms_e16_resn", core_resn, 1'b0);
    step(7);
    chk("ms_e23_resn", core_resn, 1'b0);
    step(1);
    chk("ms_e24_resn", core_resn, 1'b1);

    // synchronous reset while in RUN
    reset = 1'b1;
    step(1);
    chk("sr_resn",  core_resn, 1'b0);
    chk("sr_pin",   pin_in, 8'h00);
    chk("sr_oe",    pad_oe, 8'h00);
    chk("sr_edge",  pin_edge, 8'h00);
    reset = 1'b0;
    step(5);
    chk("sr_e5_pin",  pin_in, 8'h08);
    chk("sr_e5_edge", pin_edge, 8'h00);
    step(9);
    chk("sr_e14_resn", core_resn, 1'b0);
    step(1);
    chk("sr_e15_resn", core_resn, 1'b1);
    step(1);
    chk("sr_e16_oe", pad_oe, 8'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
